// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky
// overflow/underflow flags and an optional first-word-fall-through read port.
module param_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we_enb,
    input  logic                       re_enb,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       clr_err,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Status is decoded from the count register only, so flags never see we/re combinationally.
    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // A write into a full FIFO is still accepted when a read frees the head slot on the same edge.
    assign rd_acc = re_enb & ~empty;
    assign wr_acc = we_enb & (~full | rd_acc);

    always_ff @(posedge clk) begin
        if (!rst && wr_acc)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(wr_acc) - CW'(rd_acc);

            // New error events win over a coincident clear.
            if (we_enb && full && !rd_acc)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;

            if (re_enb && empty)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; forced to zero while empty so reset reads back 0.
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] dout_q;

            always_ff @(posedge clk) begin
                if (rst)
                    dout_q <= '0;
                else if (rd_acc)
                    dout_q <= mem[rd_ptr];
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule
